// File: rtl/genius_pkg.sv
// genius_pkg: shared state encoding, level limit and default timing for genius_ctrl.
// Revision: 1.0
`default_nettype none

package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHOW_ON  = 3'd1,
    ST_SHOW_OFF = 3'd2,
    ST_WAIT_IN  = 3'd3,
    ST_PAUSE    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_t;

  localparam logic [3:0] MAX_LEVEL = 4'd15;

  localparam int unsigned DEF_SHOW_CYCLES    = 32'd25_000_000;
  localparam int unsigned DEF_GAP_CYCLES     = 32'd12_500_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd150_000_000;

endpackage

`default_nettype wire

// File: rtl/genius_timer.sv
// genius_timer: loadable 32-bit down-counter that stops at zero and flags it.
// Revision: 1.0
`default_nettype none

module genius_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_dec,
  output logic        o_zero
);

  logic [31:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 32'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 32'd0)) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_zero = (r_count == 32'd0);

endmodule

`default_nettype wire

// File: rtl/genius_ctrl.sv
// genius_ctrl: memory-game controller; plays a growing colour sequence from an
// external ROM and checks the player's presses against it.  Revision: 1.0
`default_nettype none

module genius_ctrl
  import genius_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = DEF_SHOW_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] seq_addr,
  input  logic [3:0] seq_data,
  output logic [3:0] led,
  output logic [3:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam logic [31:0] C_SHOW_LD    = 32'(SHOW_CYCLES - 1);
  localparam logic [31:0] C_GAP_LD     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] C_TIMEOUT_LD = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_level;

  logic        w_tmr_zero;
  logic        w_tmr_load;
  logic        w_tmr_dec;
  logic [31:0] w_tmr_val;
  logic        w_press;
  logic        w_correct;

  assign w_press   = |btn;
  assign w_correct = w_press && (btn == seq_data);

  genius_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Timer reloads mirror the state transitions taken in the FSM below.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_dec  = 1'b0;
    w_tmr_val  = 32'd0;
    case (r_state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = C_SHOW_LD;
        end
      end
      ST_SHOW_ON: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = C_GAP_LD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_SHOW_OFF: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (r_idx == r_level) ? C_TIMEOUT_LD : C_SHOW_LD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_WAIT_IN: begin
        if (w_correct) begin
          if (r_idx < r_level) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = C_TIMEOUT_LD;
          end else if (r_level != MAX_LEVEL) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = C_GAP_LD;
          end
        end else if (!w_press) begin
          w_tmr_dec = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = C_SHOW_LD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_level <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start) begin
            r_level <= 4'd0;
            r_idx   <= 4'd0;
            r_state <= ST_SHOW_ON;
          end
        end
        ST_SHOW_ON: begin
          if (w_tmr_zero) r_state <= ST_SHOW_OFF;
        end
        ST_SHOW_OFF: begin
          if (w_tmr_zero) begin
            if (r_idx == r_level) begin
              r_idx   <= 4'd0;
              r_state <= ST_WAIT_IN;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= ST_SHOW_ON;
            end
          end
        end
        ST_WAIT_IN: begin
          // A press in the timeout cycle wins over the timeout.
          if (w_press) begin
            if (!w_correct) begin
              r_state <= ST_LOSE;
            end else if (r_idx < r_level) begin
              r_idx <= r_idx + 4'd1;
            end else if (r_level != MAX_LEVEL) begin
              r_level <= r_level + 4'd1;
              r_idx   <= 4'd0;
              r_state <= ST_PAUSE;
            end else begin
              r_state <= ST_WIN;
            end
          end else if (w_tmr_zero) begin
            r_state <= ST_LOSE;
          end
        end
        ST_PAUSE: begin
          if (w_tmr_zero) begin
            r_idx   <= 4'd0;
            r_state <= ST_SHOW_ON;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign seq_addr = r_idx;
  assign level    = r_level;
  assign led      = (r_state == ST_SHOW_ON) ? seq_data :
                    (r_state == ST_WIN)     ? 4'b1111  : 4'b0000;
  assign busy     = (r_state != ST_IDLE) && (r_state != ST_WIN) && (r_state != ST_LOSE);
  assign win      = (r_state == ST_WIN);
  assign lose     = (r_state == ST_LOSE);

endmodule

`default_nettype wire

// File: tb/tb_genius_ctrl.sv
// tb_genius_ctrl: directed bench for genius_ctrl with a scoreboard of expected
// LED values per cycle and a 16-entry model ROM.
`default_nettype none
`timescale 1ns/1ps

module tb_genius_ctrl;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 20;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn   = 4'b0000;
  logic [3:0] seq_addr;
  logic [3:0] seq_data;
  logic [3:0] led;
  logic [3:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  logic [3:0] rom_tbl [16] = '{
    4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0100, 4'b0001, 4'b1000, 4'b0010,
    4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b1000, 4'b0010, 4'b0100, 4'b0001
  };

  assign seq_data = rom_tbl[seq_addr];

  genius_ctrl #(
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .btn      (btn),
    .seq_addr (seq_addr),
    .seq_data (seq_data),
    .led      (led),
    .level    (level),
    .busy     (busy),
    .win      (win),
    .lose     (lose)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick();
    btn = 4'b0000;
  endtask

  // Queue the LED pattern of a playback (optionally preceded by dark pause
  // cycles), then compare one entry per cycle; optionally inject ignored inputs.
  task automatic expect_playback(input int lvl, input int lead, input bit disturb);
    logic [3:0] e;
    int n;
    for (int i = 0; i < lead; i++) exp_q.push_back(4'b0000);
    for (int k = 0; k <= lvl; k++) begin
      repeat (SHOW) exp_q.push_back(rom_tbl[k]);
      repeat (GAP)  exp_q.push_back(4'b0000);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("playback_led", led, e);
      if (disturb && n == 1) begin
        start = 1'b1;
        btn   = 4'b0110;
      end
      tick();
      start = 1'b0;
      btn   = 4'b0000;
      n++;
    end
    chk("wait_busy", {3'b0, busy}, 4'b0001);
    chk("wait_led", led, 4'b0000);
    chk("wait_addr", seq_addr, 4'b0000);
    chk("wait_level", level, 4'(lvl));
  endtask

  task automatic play_round(input int r);
    for (int k = 0; k <= r; k++) begin
      press(rom_tbl[k]);
      if (k < r) begin
        chk("idx_adv", seq_addr, 4'(k + 1));
        chk("idx_lose", {3'b0, lose}, 4'b0000);
      end
    end
    if (r < 15) begin
      chk("round_level", level, 4'(r + 1));
      chk("pause_busy", {3'b0, busy}, 4'b0001);
      expect_playback(r + 1, GAP, 1'b1);
    end else begin
      chk("win_flag", {3'b0, win}, 4'b0001);
      chk("win_led", led, 4'b1111);
      chk("win_level", level, 4'd15);
      chk("win_busy", {3'b0, busy}, 4'b0000);
      chk("win_lose", {3'b0, lose}, 4'b0000);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_led", led, 4'b0000);
    chk("rst_busy", {3'b0, busy}, 4'b0000);
    chk("rst_win", {3'b0, win}, 4'b0000);
    chk("rst_lose", {3'b0, lose}, 4'b0000);
    chk("rst_addr", seq_addr, 4'b0000);
    chk("rst_level", level, 4'b0000);

    // First start on the first edge after reset release.
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_playback(0, 0, 1'b0);

    press(4'b0001);
    chk("r0_level", level, 4'd1);
    expect_playback(1, GAP, 1'b0);

    press(4'b0010);
    chk("wrong_lose", {3'b0, lose}, 4'b0001);
    chk("wrong_led", led, 4'b0000);
    chk("wrong_busy", {3'b0, busy}, 4'b0000);
    chk("lose_level_hold", level, 4'd1);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_level", level, 4'd0);
    expect_playback(0, 0, 1'b0);

    // No press: LOSE after exactly TMO waiting cycles.
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_not_yet", {3'b0, lose}, 4'b0000);
      tick();
    end
    chk("tmo_lose", {3'b0, lose}, 4'b0001);

    start = 1'b1;
    tick();
    start = 1'b0;
    expect_playback(0, 0, 1'b0);
    repeat (TMO - 1) tick();
    press(4'b0001);
    chk("edge_press_lose", {3'b0, lose}, 4'b0000);
    chk("edge_press_level", level, 4'd1);
    expect_playback(1, GAP, 1'b1);

    for (int r = 1; r <= 15; r++) play_round(r);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("newgame_level", level, 4'd0);
    chk("newgame_led", led, rom_tbl[0]);
    tick();
    chk("pre_rst_busy", {3'b0, busy}, 4'b0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 4'b0000);
    chk("async_rst_busy", {3'b0, busy}, 4'b0000);
    chk("async_rst_addr", seq_addr, 4'b0000);
    chk("async_rst_level", level, 4'b0000);
    chk("async_rst_flags", {2'b0, win, lose}, 4'b0000);

    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_playback(0, 0, 1'b0);
    press(4'b0011);
    chk("multihot_lose", {3'b0, lose}, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
